// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared types and constants for the ccff chain loader:
//               FSM state encoding, CRC-16-CCITT polynomial and seed, and
//               a single-bit MSB-first CRC step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_ROTATE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // One step of a bit-serial, MSB-first CRC-16-CCITT.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        data_bit);
      logic fb;
      fb = crc[15] ^ data_bit;
      crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module      : ccff_crc16_serial
// Description : Bit-serial CRC-16-CCITT accumulator (MSB-first).
//               i_init reseeds to CRC_INIT and takes priority over i_en;
//               i_en folds i_bit into the running CRC.
// Ports       : prog_clk    - clock
//               pReset_n    - asynchronous active-low reset (state = CRC_INIT)
//               i_init      - reseed the CRC
//               i_en        - accumulate i_bit this cycle
//               i_bit       - serial data bit
//               o_crc       - current CRC state
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_crc16_serial
   import ccff_loader_pkg::*;
(
   input  logic        prog_clk,
   input  logic        pReset_n,
   input  logic        i_init,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_crc <= CRC_INIT;
      end else if (i_init) begin
         r_crc <= CRC_INIT;
      end else if (i_en) begin
         r_crc <= crc16_step(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Loads a configuration flip-flop (ccff) chain from a stream
//               of bitstream words, LSB first. Optionally performs a
//               non-destructive readback pass (rotating the chain through
//               itself) and compares the CRC of the read-back bits against
//               the CRC of the loaded bits.
// Ports       : prog_clk      - configuration clock (only clock)
//               pReset_n      - asynchronous active-low reset
//               start         - 1-cycle pulse in IDLE starts a load
//               verify_en     - sampled at start; enables readback pass
//               abort         - level; returns to IDLE from any state
//               word_data     - bitstream word (LSB shifted first)
//               word_valid    - word handshake valid
//               word_ready    - word handshake ready
//               ccff_head     - serial data into the chain
//               ccff_tail     - serial data out of the chain
//               config_enable - chain shift enable
//               chain_pReset  - active-high clear to the chain
//               busy          - load in progress
//               done          - 1-cycle completion pulse
//               verify_fail   - readback CRC did not match load CRC
//               crc_out       - CRC of the bits shifted into the chain
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 41,
   parameter int WORD_W    = 32
)
(
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic              verify_en,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              config_enable,
   output logic              chain_pReset,
   output logic              busy,
   output logic              done,
   output logic              verify_fail,
   output logic [15:0]       crc_out
);

   localparam int c_cnt_w     = $clog2(CHAIN_LEN + 1);
   localparam int c_buf_cnt_w = $clog2(WORD_W + 1);

   localparam logic [c_cnt_w-1:0]     c_chain_len  = c_cnt_w'(CHAIN_LEN);
   localparam logic [c_cnt_w-1:0]     c_chain_last = c_cnt_w'(CHAIN_LEN - 1);
   localparam logic [c_cnt_w-1:0]     c_cnt_one    = c_cnt_w'(1);
   localparam logic [c_buf_cnt_w-1:0] c_word_bits  = c_buf_cnt_w'(WORD_W);
   localparam logic [c_buf_cnt_w-1:0] c_buf_one    = c_buf_cnt_w'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t                   r_state;
   logic                     r_clr_cnt;      // second CLR cycle marker
   logic [WORD_W-1:0]        r_buf;          // word being serialised
   logic [c_buf_cnt_w-1:0]   r_buf_cnt;      // bits left in r_buf (0 = empty)
   logic [c_cnt_w-1:0]       r_bit_cnt;      // bits shifted into the chain
   logic [c_cnt_w-1:0]       r_rot_cnt;      // readback rotations performed
   logic                     r_verify_en;    // verify_en captured at start
   logic                     r_verify_fail;
   logic [15:0]              r_crc_out;

   logic                     w_start_ok;
   logic                     w_shift_active;
   logic                     w_last_bit;
   logic                     w_rotate;
   logic                     w_last_rot;
   logic [15:0]              w_load_crc;
   logic [15:0]              w_tail_crc;
   logic [15:0]              w_tail_crc_next;

   // ------------------------------------------------------------------------
   // Decode of the current state
   // ------------------------------------------------------------------------
   assign w_start_ok     = (r_state == ST_IDLE) && start && !abort;
   assign w_shift_active = (r_state == ST_SHIFT) && (r_buf_cnt != '0);
   assign w_last_bit     = w_shift_active && (r_bit_cnt == c_chain_last);
   assign w_rotate       = (r_state == ST_ROTATE);
   assign w_last_rot     = w_rotate && (r_rot_cnt == c_chain_last);

   // The tail CRC including the bit being read back this cycle; on the final
   // rotation this is the complete readback CRC.
   assign w_tail_crc_next = crc16_step(w_tail_crc, ccff_tail);

   // ------------------------------------------------------------------------
   // Outputs (all decoded from registers so reset forces them low)
   // ------------------------------------------------------------------------
   assign word_ready    = (r_state == ST_SHIFT) && (r_buf_cnt == '0);
   assign config_enable = w_shift_active || w_rotate;
   assign chain_pReset  = (r_state == ST_CLR);
   assign busy          = (r_state != ST_IDLE);
   assign done          = (r_state == ST_DONE);
   assign verify_fail   = r_verify_fail;
   assign crc_out       = r_crc_out;

   // During ROTATE the chain is closed into a loop so its contents return
   // to where they started after CHAIN_LEN shifts.
   always_comb begin
      ccff_head = 1'b0;
      if (w_shift_active) begin
         ccff_head = r_buf[0];
      end else if (w_rotate) begin
         ccff_head = ccff_tail;
      end
   end

   // ------------------------------------------------------------------------
   // CRC accumulators: one over loaded bits, one over read-back bits
   // ------------------------------------------------------------------------
   ccff_crc16_serial u_load_crc (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .i_init   (w_start_ok),
      .i_en     (w_shift_active && !abort),
      .i_bit    (r_buf[0]),
      .o_crc    (w_load_crc)
   );

   ccff_crc16_serial u_tail_crc (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .i_init   (w_start_ok),
      .i_en     (w_rotate && !abort),
      .i_bit    (ccff_tail),
      .o_crc    (w_tail_crc)
   );

   // ------------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_state       <= ST_IDLE;
         r_clr_cnt     <= 1'b0;
         r_buf         <= '0;
         r_buf_cnt     <= '0;
         r_bit_cnt     <= '0;
         r_rot_cnt     <= '0;
         r_verify_en   <= 1'b0;
         r_verify_fail <= 1'b0;
         r_crc_out     <= 16'h0000;
      end else if (abort) begin
         // Abort wins over every transition, including a coincident start.
         // verify_fail and crc_out keep their values.
         r_state   <= ST_IDLE;
         r_clr_cnt <= 1'b0;
         r_buf     <= '0;
         r_buf_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state       <= ST_CLR;
                  r_clr_cnt     <= 1'b0;
                  r_buf_cnt     <= '0;
                  r_bit_cnt     <= '0;
                  r_rot_cnt     <= '0;
                  r_verify_fail <= 1'b0;
                  r_verify_en   <= verify_en;
               end
            end

            ST_CLR: begin
               // chain_pReset is held for exactly two cycles
               if (r_clr_cnt) begin
                  r_clr_cnt <= 1'b0;
                  r_state   <= ST_SHIFT;
               end else begin
                  r_clr_cnt <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (w_shift_active) begin
                  r_buf     <= r_buf >> 1;
                  r_buf_cnt <= r_buf_cnt - c_buf_one;
                  if (r_bit_cnt != c_chain_len) begin
                     r_bit_cnt <= r_bit_cnt + c_cnt_one;
                  end
                  if (w_last_bit) begin
                     // Chain is full: drop whatever is left of the word
                     r_buf     <= '0;
                     r_buf_cnt <= '0;
                     r_rot_cnt <= '0;
                     r_crc_out <= crc16_step(w_load_crc, r_buf[0]);
                     r_state   <= r_verify_en ? ST_ROTATE : ST_DONE;
                  end
               end else if (word_valid) begin
                  // word_ready is high whenever the buffer is empty here
                  r_buf     <= word_data;
                  r_buf_cnt <= c_word_bits;
               end
            end

            ST_ROTATE: begin
               if (w_last_rot) begin
                  r_verify_fail <= (w_tail_crc_next != w_load_crc);
                  r_state       <= ST_DONE;
               end else begin
                  r_rot_cnt <= r_rot_cnt + c_cnt_one;
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Self-checking bench for ccff_chain_loader with a 41-bit
//               shift-register chain model (optional stuck-at-0 bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 41;
   localparam int WORD_W    = 32;

   logic              prog_clk;
   logic              pReset_n;
   logic              start;
   logic              verify_en;
   logic              abort;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;
   logic              ccff_head;
   logic              ccff_tail;
   logic              config_enable;
   logic              chain_pReset;
   logic              busy;
   logic              done;
   logic              verify_fail;
   logic [15:0]       crc_out;

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
      .prog_clk      (prog_clk),
      .pReset_n      (pReset_n),
      .start         (start),
      .verify_en     (verify_en),
      .abort         (abort),
      .word_data     (word_data),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail),
      .config_enable (config_enable),
      .chain_pReset  (chain_pReset),
      .busy          (busy),
      .done          (done),
      .verify_fail   (verify_fail),
      .crc_out       (crc_out)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // Chain model: head enters at bit 40, tail leaves from bit 0, so after a
   // full load the first streamed bit sits in bit 0.
   logic [40:0] chain;
   logic [40:0] stuck_mask;
   always @(posedge prog_clk) begin
      chain <= (chain_pReset  ? 41'h0 :
                config_enable ? {ccff_head, chain[40:1]} : chain) & stuck_mask;
   end
   assign ccff_tail = chain[0];

   int n_tests = 0;
   int n_fail  = 0;

   int m_cfg, m_gap, m_xfer, m_done, m_clr;
   logic m_timeout;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Golden CRC-16-CCITT over the 41 streamed bits, stream bit 0 first.
   function automatic logic [15:0] crc_model(input logic [40:0] s);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < 41; i++) begin
         if (c[15] ^ s[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Runs one load. Starts and ends at posedge+1. abort_at / rst_at (bit
   // counts, 0 = unused) end the task right after triggering the event.
   task automatic run_load(input logic ven, input logic [31:0] w0, input logic [31:0] w1,
                           input int stall, input int abort_at, input int rst_at);
      int   idx = 0;
      int   stall_cnt = 0;
      int   stall_phase = 0;
      int   post = 0;
      logic xfer;
      logic seen_done = 1'b0;
      logic finished = 1'b0;
      m_cfg = 0; m_gap = 0; m_xfer = 0; m_done = 0; m_clr = 0; m_timeout = 1'b1;
      verify_en  = ven;
      word_data  = w0;
      word_valid = 1'b1;
      start      = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(negedge prog_clk);
         xfer = word_valid && word_ready;
         if (config_enable) m_cfg++;
         if (chain_pReset)  m_clr++;
         if (busy && !chain_pReset && !config_enable && !done) m_gap++;
         if (xfer) m_xfer++;
         if (done) begin m_done++; seen_done = 1'b1; end
         if (stall_phase == 1 && word_ready && !word_valid) stall_cnt++;
         @(posedge prog_clk); #1;
         if (xfer) begin
            idx++;
            word_data  = w1;
            word_valid = (idx < 2);
         end
         if (stall > 0 && stall_phase == 0 && m_cfg == 16) begin
            word_valid  = 1'b0;
            stall_phase = 1;
         end else if (stall_phase == 1 && stall_cnt == stall) begin
            word_valid  = 1'b1;
            stall_phase = 2;
         end
         if (abort_at > 0 && m_cfg == abort_at) begin
            abort = 1'b1;
            finished = 1'b1; m_timeout = 1'b0;
         end
         if (rst_at > 0 && m_cfg == rst_at) begin
            #2 pReset_n = 1'b0;
            #1;
            finished = 1'b1; m_timeout = 1'b0;
         end
         if (seen_done) begin
            post++;
            if (post == 3) begin finished = 1'b1; m_timeout = 1'b0; end
         end
      end
      word_valid = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic        ven;
      logic [31:0] w0;
      logic [31:0] w1;
      int          stall;
      int          stuck;      // -1 = no stuck bit
      logic [40:0] exp_chain;
      logic        chk_chain;
      int          exp_cfg;
      int          exp_gap;
      logic        exp_vfail;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{"plain",   1'b0, 32'hDEADBEEF, 32'h000001A5,  0, -1, 41'h1A5DEADBEEF, 1'b1, 41,  2, 1'b0};
      vecs[1] = '{"verify",  1'b1, 32'hDEADBEEF, 32'h000001A5,  0, -1, 41'h1A5DEADBEEF, 1'b1, 82,  2, 1'b0};
      vecs[2] = '{"stuck",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,  0, 20, 41'h0,           1'b0, 82,  2, 1'b1};
      vecs[3] = '{"stall",   1'b0, 32'hDEADBEEF, 32'h000001A5, 10, -1, 41'h1A5DEADBEEF, 1'b1, 41, 12, 1'b0};
      vecs[4] = '{"discard", 1'b1, 32'h12345678, 32'hABCDE0AA,  0, -1, 41'h0AA12345678, 1'b1, 82,  2, 1'b0};

      stuck_mask = '1;
      start = 1'b0; verify_en = 1'b0; abort = 1'b0;
      word_data = '0; word_valid = 1'b0;
      pReset_n = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge prog_clk);
      #1;
      check("reset/outs", {word_ready, config_enable, ccff_head, chain_pReset, busy, done, verify_fail}, 0);
      check("reset/crc_out", crc_out, 16'h0000);
      pReset_n = 1'b1;
      @(posedge prog_clk); #1;

      // ---------------- table-driven loads ----------------
      for (int i = 0; i < 5; i++) begin
         stuck_mask = '1;
         if (vecs[i].stuck >= 0) stuck_mask[vecs[i].stuck] = 1'b0;
         run_load(vecs[i].ven, vecs[i].w0, vecs[i].w1, vecs[i].stall, 0, 0);
         check($sformatf("%s/timeout", vecs[i].name), m_timeout, 0);
         check($sformatf("%s/cfg_cycles", vecs[i].name), m_cfg, vecs[i].exp_cfg);
         check($sformatf("%s/gap_cycles", vecs[i].name), m_gap, vecs[i].exp_gap);
         check($sformatf("%s/xfers", vecs[i].name), m_xfer, 2);
         check($sformatf("%s/clr_cycles", vecs[i].name), m_clr, 2);
         check($sformatf("%s/done_pulses", vecs[i].name), m_done, 1);
         check($sformatf("%s/verify_fail", vecs[i].name), verify_fail, vecs[i].exp_vfail);
         check($sformatf("%s/crc_out", vecs[i].name), crc_out,
               crc_model({vecs[i].w1[8:0], vecs[i].w0}));
         if (vecs[i].chk_chain)
            check($sformatf("%s/chain", vecs[i].name), chain, vecs[i].exp_chain);
      end
      stuck_mask = '1;

      // ---------------- start coincident with abort is ignored ----------------
      start = 1'b1; abort = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0; abort = 1'b0;
      check("start_abort/busy", busy, 0);
      @(posedge prog_clk); #1;
      check("start_abort/busy_later", {busy, chain_pReset}, 0);

      // ---------------- abort at bit 20 ----------------
      run_load(1'b0, 32'hDEADBEEF, 32'h000001A5, 0, 20, 0);
      check("abort/reached", m_timeout, 0);
      check("abort/cfg_before", config_enable, 1);
      @(posedge prog_clk); #1;
      abort = 1'b0;
      check("abort/idle_next", {busy, config_enable, word_ready, done}, 0);
      m_done = 0;
      repeat (4) begin
         @(negedge prog_clk);
         if (done) m_done++;
      end
      @(posedge prog_clk); #1;
      check("abort/no_done", m_done, 0);
      run_load(1'b0, 32'hDEADBEEF, 32'h000001A5, 0, 0, 0);
      check("abort_reload/done", m_done, 1);
      check("abort_reload/chain", chain, 41'h1A5DEADBEEF);

      // ---------------- reset mid-ROTATE ----------------
      run_load(1'b1, 32'hDEADBEEF, 32'h000001A5, 0, 0, 51);
      check("rst_rot/reached", m_timeout, 0);
      check("rst_rot/outs", {word_ready, config_enable, ccff_head, chain_pReset, busy, done, verify_fail}, 0);
      check("rst_rot/crc_out", crc_out, 16'h0000);
      repeat (2) @(posedge prog_clk);
      #1 pReset_n = 1'b1;
      repeat (5) @(posedge prog_clk);
      #1;
      check("rst_rot/stays_idle", {busy, config_enable, chain_pReset}, 0);
      run_load(1'b1, 32'h12345678, 32'hABCDE0AA, 0, 0, 0);
      check("rst_reload/done", m_done, 1);
      check("rst_reload/cfg_cycles", m_cfg, 82);
      check("rst_reload/chain", chain, 41'h0AA12345678);
      check("rst_reload/verify_fail", verify_fail, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
